// File: rtl/keypad_scan_ctrl_pkg.sv
// Purpose : shared types and defaults for the 4x4 keypad scanner.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: FSM state encoding, default prescaler/debounce values, bit-index helper.
package keypad_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    // 1.25 ms scan tick at 100 MHz.
    localparam int unsigned SCAN_DIV_DEF  = 125000;
    localparam int unsigned DEB_TICKS_DEF = 8;

    // Index of the lowest set bit; a multi-row press resolves to the lowest row.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        if (v[2]) idx = 2'd2;
        if (v[1]) idx = 2'd1;
        if (v[0]) idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_tick.sv
// Purpose : free-running prescaler producing a one-clk scan tick every DIV clocks.
// Latency : first tick is seen by the consumer DIV clocks after reset release.
// Backpr. : none; the tick is a strobe and cannot be stalled.
// Ports   : clk, reset_p (async, active-high), tick (one-clk pulse when count == DIV-1).
module scan_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);

    localparam int unsigned        CW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]      LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Purpose : 4x4 keypad column scanner with press/release debounce and key code output.
// Latency : row is synchronized over 2 clk; a press is confirmed after DEB_TICKS stable ticks.
// Backpr. : none; key_valid is a one-clk strobe, key_value holds until the next press.
// Ports   : clk, reset_p (async, active-high), row[3:0] in (async, active-high),
//           col[3:0] one-hot drive, key_value[3:0] = row_idx*4+col_idx, key_valid, key_busy.
module keypad_scan_ctrl
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
    parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_busy
);

    localparam logic [4:0] DEB_LIM = 5'(DEB_TICKS);

    logic       tick;
    logic [3:0] row_m_q, row_s_q;
    kp_state_t  state_q, state_d;
    logic [3:0] col_q, col_d;
    logic [3:0] snap_q, snap_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic [3:0] key_value_q, key_value_d;
    logic       key_valid_q, key_valid_d;
    logic       key_busy_q, key_busy_d;
    logic [4:0] deb_inc;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick)
    );

    // Two-stage synchronizer on the asynchronous row lines.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            row_m_q <= '0;
            row_s_q <= '0;
        end else begin
            row_m_q <= row;
            row_s_q <= row_m_q;
        end
    end

    // Widened so the compare against DEB_TICKS cannot wrap at 15.
    assign deb_inc = {1'b0, deb_cnt_q} + 5'd1;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        snap_d      = snap_q;
        deb_cnt_d   = deb_cnt_q;
        key_value_d = key_value_q;
        key_valid_d = 1'b0;
        key_busy_d  = key_busy_q;

        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (row_s_q == 4'd0) begin
                        col_d = {col_q[2:0], col_q[3]};
                    end else begin
                        // Column stays put so the pressed key stays energized.
                        state_d   = ST_DEBOUNCE;
                        snap_d    = row_s_q;
                        deb_cnt_d = 4'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s_q == snap_q) begin
                        deb_cnt_d = deb_inc[3:0];
                        if (deb_inc >= DEB_LIM) begin
                            state_d     = ST_PRESSED;
                            key_valid_d = 1'b1;
                            key_busy_d  = 1'b1;
                            key_value_d = {low_idx(snap_q), low_idx(col_q)};
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        deb_cnt_d = 4'd0;
                    end
                end
                ST_PRESSED: begin
                    if (row_s_q == 4'd0) begin
                        state_d   = ST_RELEASE;
                        deb_cnt_d = 4'd1;
                    end
                end
                ST_RELEASE: begin
                    if (row_s_q == 4'd0) begin
                        deb_cnt_d = deb_inc[3:0];
                        if (deb_inc >= DEB_LIM) begin
                            state_d    = ST_SCAN;
                            key_busy_d = 1'b0;
                            deb_cnt_d  = 4'd0;
                            col_d      = {col_q[2:0], col_q[3]};
                        end
                    end else begin
                        // Release bounced: key is still held, no new strobe.
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= ST_SCAN;
            col_q       <= 4'b0001;
            snap_q      <= '0;
            deb_cnt_q   <= '0;
            key_value_q <= '0;
            key_valid_q <= 1'b0;
            key_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            snap_q      <= snap_d;
            deb_cnt_q   <= deb_cnt_d;
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
            key_busy_q  <= key_busy_d;
        end
    end

    assign col       = col_q;
    assign key_value = key_value_q;
    assign key_valid = key_valid_q;
    assign key_busy  = key_busy_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Purpose : directed self-checking bench for keypad_scan_ctrl (SCAN_DIV=4, DEB_TICKS=3).
// Latency : scan ticks act on every 4th rising edge after reset release (edges E4, E8, ...).
// Backpr. : n/a.
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       reset_p;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .row       (row),
        .col       (col),
        .key_value (key_value),
        .key_valid (key_valid),
        .key_busy  (key_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts key_valid strobes, sampled away from the active edge.
    always @(negedge clk) begin
        if (key_valid === 1'b1) vld_cnt = vld_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_p = 1'b1;
        row     = 4'd0;
        step(3);
        chk("rst_col",   8'(col),       8'h1);
        chk("rst_value", 8'(key_value), 8'h0);
        chk("rst_valid", 8'(key_valid), 8'h0);
        chk("rst_busy",  8'(key_busy),  8'h0);
        reset_p = 1'b0;                       // E0

        // Idle scan: each column held 4 clk.
        step(3);  chk("idle_e3_col",  8'(col), 8'h1);
        step(1);  chk("idle_e4_col",  8'(col), 8'h2);
        step(4);  chk("idle_e8_col",  8'(col), 8'h4);
        step(3);  chk("idle_e11_col", 8'(col), 8'h4);
        step(1);  chk("idle_e12_col", 8'(col), 8'h8);
        step(4);  chk("idle_e16_col", 8'(col), 8'h1);
        chk("idle_busy", 8'(key_busy), 8'h0);
        chk("idle_vld",  8'(vld_cnt),  8'h0);

        // Stable press on row 2 while col=0010 -> key 9.
        step(4);  chk("p1_e20_col", 8'(col), 8'h2);
        row = 4'b0100;
        step(11);
        chk("p1_pre_valid", 8'(key_valid), 8'h0);
        chk("p1_pre_busy",  8'(key_busy),  8'h0);
        chk("p1_pre_col",   8'(col),       8'h2);
        step(1);                              // E32
        chk("p1_valid", 8'(key_valid), 8'h1);
        chk("p1_value", 8'(key_value), 8'h9);
        chk("p1_busy",  8'(key_busy),  8'h1);
        chk("p1_col",   8'(col),       8'h2);
        step(1);  chk("p1_valid_off", 8'(key_valid), 8'h0);

        // Held for 20 ticks total, then released.
        step(27);                             // E60
        chk("hold_col",  8'(col),      8'h2);
        chk("hold_busy", 8'(key_busy), 8'h1);
        step(40);                             // E100
        row = 4'd0;
        step(11);                             // E111
        chk("rel_pre_busy", 8'(key_busy), 8'h1);
        chk("rel_pre_col",  8'(col),      8'h2);
        step(1);                              // E112
        chk("rel_busy",  8'(key_busy),  8'h0);
        chk("rel_col",   8'(col),       8'h4);
        chk("rel_value", 8'(key_value), 8'h9);
        chk("rel_vld",   8'(vld_cnt),   8'h1);

        // Bounce: one tick of row 2 at col 0010, then gone.
        step(12); chk("b_e124_col", 8'(col), 8'h2);
        row = 4'b0100;
        step(4);  chk("b_e128_col", 8'(col), 8'h2);
        row = 4'd0;
        step(4);  chk("b_e132_col", 8'(col), 8'h2);
        step(4);
        chk("b_e136_col", 8'(col),      8'h4);
        chk("b_busy",     8'(key_busy), 8'h0);
        chk("b_vld",      8'(vld_cnt),  8'h1);

        // Multi-row press 1010 at col 0001 -> lowest row 1 -> key 4.
        step(8);  chk("m_e144_col", 8'(col), 8'h1);
        row = 4'b1010;
        step(11); chk("m_pre_valid", 8'(key_valid), 8'h0);
        step(1);                              // E156
        chk("m_valid", 8'(key_valid), 8'h1);
        chk("m_value", 8'(key_value), 8'h4);
        chk("m_busy",  8'(key_busy),  8'h1);
        chk("m_col",   8'(col),       8'h1);

        // Reset in the middle of a held press.
        step(4);                              // E160
        chk("m_vld", 8'(vld_cnt), 8'h2);
        reset_p = 1'b1;
        row     = 4'd0;
        #1;
        chk("r2_col",   8'(col),       8'h1);
        chk("r2_value", 8'(key_value), 8'h0);
        chk("r2_valid", 8'(key_valid), 8'h0);
        chk("r2_busy",  8'(key_busy),  8'h0);
        step(2);
        reset_p = 1'b0;                       // F0
        step(3);  chk("r2_f3_col", 8'(col), 8'h1);
        step(1);  chk("r2_f4_col", 8'(col), 8'h2);
        step(16);
        chk("r2_busy_after", 8'(key_busy), 8'h0);
        chk("r2_vld",        8'(vld_cnt),  8'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
